load_feeder: RTL and testbench



---
 rtl/load_feeder_pkg.sv | 14 +
 rtl/load_feeder_if.sv | 30 +++
 rtl/load_feeder_fifo.sv | 63 ++++++
 rtl/load_feeder.sv | 90 +++++++++
 tb/tb_load_feeder.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/load_feeder_pkg.sv
// Shared types and helpers for the load feeder: FSM state encoding and
// the width of the buffered-word counter.
package load_feeder_pkg;

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      GAP_WAIT = 1'b1
   } feeder_state_t;

   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/load_feeder_if.sv
// Stream-in / load-out bundle of the load feeder. The master side is the
// word source plus downstream control; the slave side is the feeder.
interface load_feeder_if
   import load_feeder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
);
   localparam int CNT_W = count_width(DEPTH);

   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             stall;
   logic             flush;
   logic [WIDTH-1:0] d;
   logic             load;
   logic [CNT_W-1:0] count;

   modport master (
      output in_valid, in_data, stall, flush,
      input  in_ready, d, load, count
   );

   modport slave (
      input  in_valid, in_data, stall, flush,
      output in_ready, d, load, count
   );

endinterface

// File: rtl/load_feeder_fifo.sv
// Small synchronous FIFO with flush; head word is visible combinationally
// so the feeder can register it on the same edge it pops.
module load_feeder_fifo
   import load_feeder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          push,
   input  logic                          pop,
   input  logic                          flush,
   input  logic [WIDTH-1:0]              wr_data,
   output logic [WIDTH-1:0]              rd_data,
   output logic [count_width(DEPTH)-1:0] count,
   output logic                          full,
   output logic                          empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = count_width(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign rd_data = mem[rd_ptr];

   // Storage carries no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push_ok && !flush)
         mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/load_feeder.sv
// Load feeder: buffers stream words and issues each as a one-cycle load
// strobe with registered d, enforcing a minimum idle gap between loads.
module load_feeder
   import load_feeder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4,
   parameter int GAP   = 2
) (
   input  logic         clk,
   input  logic         reset_n,
   load_feeder_if.slave bus
);
   localparam int          CW       = count_width(DEPTH);
   localparam int          GW       = (GAP > 1) ? $clog2(GAP) : 1;
   localparam int          GAP_M1   = (GAP > 0) ? GAP - 1 : 0;
   localparam logic [0:0]  ST_IDLE  = 1'(IDLE);
   localparam logic [0:0]  ST_GAP   = 1'(GAP_WAIT);
   localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_M1);

   logic [0:0]       state;
   logic [GW-1:0]    gap_cnt;
   logic [WIDTH-1:0] d_p0;
   logic             vld_p0;

   logic             push;
   logic             issue;
   logic             full;
   logic             empty;
   logic [WIDTH-1:0] head;
   logic [CW-1:0]    fifo_count;

   assign bus.in_ready = reset_n && !full && !bus.flush;
   assign push         = bus.in_valid && bus.in_ready;
   assign issue        = (state == ST_IDLE) && !empty && !bus.stall && !bus.flush;

   load_feeder_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .pop     (issue),
      .flush   (bus.flush),
      .wr_data (bus.in_data),
      .rd_data (head),
      .count   (fifo_count),
      .full    (full),
      .empty   (empty)
   );

   // Issue stage: d only moves on an issue edge so it is stable between pulses.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         d_p0   <= '0;
         vld_p0 <= 1'b0;
      end else begin
         vld_p0 <= issue;
         if (issue)
            d_p0 <= head;
      end
   end

   // Gap countdown runs regardless of stall; flush forces a fresh IDLE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         gap_cnt <= '0;
      end else if (bus.flush) begin
         state   <= ST_IDLE;
         gap_cnt <= '0;
      end else if (issue) begin
         if (GAP > 0) begin
            state   <= ST_GAP;
            gap_cnt <= GAP_LOAD;
         end
      end else if (state == ST_GAP) begin
         if (gap_cnt == '0)
            state <= ST_IDLE;
         else
            gap_cnt <= gap_cnt - GW'(1);
      end
   end

   assign bus.d     = d_p0;
   assign bus.load  = vld_p0;
   assign bus.count = fifo_count;

endmodule

// File: tb/tb_load_feeder.sv
// Scoreboard bench for load_feeder: one instance with GAP=2, one with GAP=0.
module tb_load_feeder;

   logic clk;
   logic rst_n;

   load_feeder_if #(.WIDTH(16), .DEPTH(4)) b2 ();
   load_feeder_if #(.WIDTH(16), .DEPTH(4)) b0 ();

   load_feeder #(.WIDTH(16), .DEPTH(4), .GAP(2)) dut2 (
      .clk     (clk),
      .reset_n (rst_n),
      .bus     (b2)
   );

   load_feeder #(.WIDTH(16), .DEPTH(4), .GAP(0)) dut0 (
      .clk     (clk),
      .reset_n (rst_n),
      .bus     (b0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [15:0] q2[$];
   logic [15:0] q0[$];
   int          lc2[$];
   int          cyc = 0;
   int          ld_cnt2 = 0;
   int          ld_cnt0 = 0;
   int          peak2 = 0;
   logic [15:0] last_d2 = 16'h0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Present a word on the GAP=2 instance and hold it until accepted.
   task automatic send2(input logic [15:0] w);
      int n;
      n = 0;
      b2.in_valid = 1'b1;
      b2.in_data  = w;
      #1;
      while (!b2.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("send2_timeout", n, 0);
      @(posedge clk);
      q2.push_back(w);
      #1;
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Output monitors: data order and minimum spacing.
   initial begin
      bit          have_last;
      int          last_cyc;
      logic [15:0] e;
      have_last = 0;
      last_cyc  = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            have_last = 0;
         end else begin
            if (int'(b2.count) > peak2) peak2 = int'(b2.count);
            if (b2.load) begin
               if (q2.size() == 0) begin
                  check("d2_unexpected_load", b2.load, 1'b0);
               end else begin
                  e = q2.pop_front();
                  check("d2_data", b2.d, e);
                  last_d2 = e;
               end
               if (have_last) check("gap2_min_spacing", (cyc - last_cyc) >= 3, 1'b1);
               have_last = 1;
               last_cyc  = cyc;
               lc2.push_back(cyc);
               ld_cnt2++;
            end
            if (b0.load) begin
               if (q0.size() == 0) check("d0_unexpected_load", b0.load, 1'b0);
               else check("d0_data", b0.d, q0.pop_front());
               ld_cnt0++;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      b2.in_valid = 1'b0; b2.in_data = '0; b2.stall = 1'b0; b2.flush = 1'b0;
      b0.in_valid = 1'b0; b0.in_data = '0; b0.stall = 1'b0; b0.flush = 1'b0;
      #2;
      check("rst_in_ready", b2.in_ready, 1'b0);
      check("rst_load",     b2.load,     1'b0);
      check("rst_d",        b2.d,        16'h0);
      check("rst_count",    b2.count,    3'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_rst_in_ready", b2.in_ready, 1'b1);

      // Single word, one-cycle latency.
      send2(16'hA5A5);
      b2.in_valid = 1'b0;
      @(negedge clk);
      check("single_no_early_load", b2.load, 1'b0);
      @(negedge clk);
      check("single_load", b2.load, 1'b1);
      check("single_d",    b2.d,    16'hA5A5);
      @(negedge clk);
      check("single_load_drop", b2.load, 1'b0);
      check("single_d_hold",    b2.d,    16'hA5A5);
      repeat (5) @(negedge clk);

      // Back-to-back burst; loads must be spaced by exactly 3 cycles.
      lc2.delete();
      peak2 = 0;
      for (int i = 1; i <= 4; i++) send2(16'(i));
      b2.in_valid = 1'b0;
      repeat (15) @(negedge clk);
      check("burst_loads", lc2.size(), 4);
      if (lc2.size() == 4)
         for (int i = 1; i < 4; i++) check("burst_spacing", lc2[i] - lc2[i-1], 3);
      check("burst_peak_count", peak2, 3);
      check("burst_last_d", b2.d, 16'h0004);

      // Stall holds words; then fill to DEPTH and hold an extra word at the source.
      b2.stall = 1'b1;
      send2(16'h1111);
      send2(16'h2222);
      b2.in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_no_load", b2.load, 1'b0);
      end
      check("stall_count", b2.count, 3'd2);
      send2(16'h3333);
      send2(16'h4444);
      b2.in_data = 16'h5555;
      @(negedge clk);
      check("full_count",    b2.count,    3'd4);
      check("full_in_ready", b2.in_ready, 1'b0);
      @(negedge clk);
      b2.stall = 1'b0;
      send2(16'h5555);
      b2.in_valid = 1'b0;
      repeat (25) @(negedge clk);
      check("stall_drain_count", b2.count, 3'd0);
      check("stall_drain_queue", q2.size(), 0);

      // Flush with a word on the stream; it must not be stored.
      b2.stall = 1'b1;
      send2(16'hC001);
      send2(16'hC002);
      send2(16'hC003);
      b2.in_data = 16'hDEAD;
      b2.flush   = 1'b1;
      #1;
      check("flush_in_ready", b2.in_ready, 1'b0);
      @(posedge clk);
      #1;
      b2.flush    = 1'b0;
      b2.in_valid = 1'b0;
      q2.delete();
      check("flush_count", b2.count, 3'd0);
      check("flush_load",  b2.load,  1'b0);
      check("flush_d",     b2.d,     last_d2);
      b2.stall = 1'b0;
      repeat (8) @(negedge clk);
      check("flush_stays_empty", b2.count, 3'd0);

      // Async reset while the GAP countdown is running.
      send2(16'h7777);
      b2.in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("pre_reset_load", b2.load, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("areset_load",     b2.load,     1'b0);
      check("areset_d",        b2.d,        16'h0);
      check("areset_count",    b2.count,    3'd0);
      check("areset_in_ready", b2.in_ready, 1'b0);
      q2.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      send2(16'h8888);
      b2.in_valid = 1'b0;
      @(negedge clk);
      check("post_areset_no_early", b2.load, 1'b0);
      @(negedge clk);
      check("post_areset_load", b2.load, 1'b1);
      check("post_areset_d",    b2.d,    16'h8888);
      repeat (4) @(negedge clk);

      // GAP=0: continuous stream, one load per cycle, count stays at 1.
      @(posedge clk);
      #1;
      b0.in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         b0.in_data = 16'h0010 + 16'(i);
         #1;
         check("gap0_in_ready", b0.in_ready, 1'b1);
         if (i >= 1) check("gap0_count", b0.count, 3'd1);
         if (i >= 2) check("gap0_load", b0.load, 1'b1);
         @(posedge clk);
         q0.push_back(b0.in_data);
         #1;
      end
      b0.in_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("gap0_total_loads", ld_cnt0, 8);
      check("gap0_queue_empty", q0.size(), 0);
      check("gap2_queue_empty", q2.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
